ippcrc_crc12_40b_eng: RTL and testbench

Sequential CRC-12 framing engine that sits directly upstream of the ippcrc CRC-12 40-bit-parallel combinational update core. It accepts a stream of 40-bit words with valid/ready, sop and eop, and on every accepted word presents the running CRC state (ci) and the word (di) to the core. It registers the core's next state (co), and on eop emits one 12-bit CRC result per frame. In check mode it also emits a pass/fail flag against an expected CRC.

---
 rtl/ippcrc_crc12_40b_eng.sv | 227 ++++++++++++++++++++++
 tb/tb_ippcrc_crc12_40b_eng.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ippcrc_crc12_40b_eng.sv
// CRC-12 (poly 0x80F) framing engine around a 40-bit-parallel update core.
// Optional macro IPPCRC_CRC12_ENG_STAT_EN adds frame/bad-frame statistics outputs.

module ippcrc_crc12_40b_core (
  input  logic [11:0] i_ci,
  input  logic [39:0] i_di,
  output logic [11:0] o_co
);
  localparam logic [11:0] POLY = 12'h80F;

  logic [11:0] w_c;
  logic        w_fb;

  // di[0] enters the division first, di[39] last; the loop unrolls into an XOR network.
  always_comb begin
    w_c  = i_ci;
    w_fb = 1'b0;
    for (int j = 0; j < 40; j++) begin
      w_fb = w_c[11] ^ i_di[j];
      w_c  = {w_c[10:0], 1'b0} ^ (w_fb ? POLY : 12'h000);
    end
    o_co = w_c;
  end
endmodule

module ippcrc_crc12_40b_eng #(
  parameter logic [11:0] CRC_INIT = 12'h000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mode,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic [39:0]      i_dat,
  input  logic [11:0]      i_crc_exp,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [11:0]      o_crc,
  output logic             o_chk_ok,
  output logic [CNT_W-1:0] o_wcnt,
  output logic             o_err
`ifdef IPPCRC_CRC12_ENG_STAT_EN
  ,
  output logic [31:0]      o_frm_cnt,
  output logic [31:0]      o_bad_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [11:0]      r_crc;
  logic [CNT_W-1:0] r_wcnt;
  logic             r_mode;
  logic             r_o_vld;
  logic [11:0]      r_o_crc;
  logic             r_o_chk;
  logic [CNT_W-1:0] r_o_wcnt;
  logic             r_err;

  logic             w_acc;
  logic             w_take;
  logic [11:0]      w_ci;
  logic [11:0]      w_co;
  logic             w_upd;
  logic             w_load;
  logic             w_err;
  logic             w_mode_eff;
  logic             w_chk;
  logic [CNT_W-1:0] w_cnt_nxt;

  ippcrc_crc12_40b_core u_core (
    .i_ci (w_ci),
    .i_di (i_dat),
    .o_co (w_co)
  );

  // A pending result blocks input unless it is being taken this very cycle.
  assign i_rdy  = !rst && !(r_o_vld && !o_rdy);
  assign w_acc  = i_vld && i_rdy;
  assign w_take = r_o_vld && o_rdy;
  assign w_ci   = i_sop ? CRC_INIT : r_crc;

  // Per-word datapath values: effective mode, saturating count and check result.
  always_comb begin
    w_mode_eff = i_sop ? i_mode : r_mode;
    if (i_sop) begin
      w_cnt_nxt = CNT_ONE;
    end else if (r_wcnt == CNT_MAX) begin
      w_cnt_nxt = r_wcnt;
    end else begin
      w_cnt_nxt = r_wcnt + CNT_ONE;
    end
    if (w_mode_eff) begin
      w_chk = (w_co == i_crc_exp);
    end else begin
      w_chk = 1'b1;
    end
  end

  // Next-state and control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_load      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (i_sop) begin
            w_upd       = 1'b1;
            w_load      = i_eop;
            w_state_nxt = i_eop ? ST_DONE : ST_RUN;
          end else begin
            w_err       = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A sop here abandons the open frame and restarts on this word.
        if (w_acc) begin
          w_upd       = 1'b1;
          w_err       = i_sop;
          w_load      = i_eop;
          w_state_nxt = i_eop ? ST_DONE : ST_RUN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (w_take) begin
          w_state_nxt = ST_IDLE;
          if (w_acc) begin
            if (i_sop) begin
              w_upd       = 1'b1;
              w_load      = i_eop;
              w_state_nxt = i_eop ? ST_DONE : ST_RUN;
            end else begin
              w_err       = 1'b1;
            end
          end else begin
            w_err       = 1'b0;
          end
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register, running CRC and result buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_crc    <= CRC_INIT;
      r_wcnt   <= {CNT_W{1'b0}};
      r_mode   <= 1'b0;
      r_o_vld  <= 1'b0;
      r_o_crc  <= 12'h000;
      r_o_chk  <= 1'b0;
      r_o_wcnt <= {CNT_W{1'b0}};
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_upd) begin
        r_crc  <= w_co;
        r_wcnt <= w_cnt_nxt;
        r_mode <= w_mode_eff;
      end
      // A new load wins over the handshake that frees the buffer in the same cycle.
      if (w_load) begin
        r_o_vld  <= 1'b1;
        r_o_crc  <= w_co;
        r_o_chk  <= w_chk;
        r_o_wcnt <= w_cnt_nxt;
      end else if (w_take) begin
        r_o_vld  <= 1'b0;
      end
    end
  end

  assign o_vld    = r_o_vld;
  assign o_crc    = r_o_crc;
  assign o_chk_ok = r_o_chk;
  assign o_wcnt   = r_o_wcnt;
  assign o_err    = r_err;

`ifdef IPPCRC_CRC12_ENG_STAT_EN
  logic [31:0] r_frm_cnt;
  logic [31:0] r_bad_cnt;
  logic        w_bad_hs;

  assign w_bad_hs = w_take && !r_o_chk;

  // Wrapping statistics; a failed check and an error pulse in one cycle both count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frm_cnt <= 32'd0;
      r_bad_cnt <= 32'd0;
    end else begin
      r_frm_cnt <= r_frm_cnt + {31'd0, w_take};
      r_bad_cnt <= r_bad_cnt + {31'd0, w_bad_hs} + {31'd0, r_err};
    end
  end

  assign o_frm_cnt = r_frm_cnt;
  assign o_bad_cnt = r_bad_cnt;
`endif

endmodule

// File: tb/tb_ippcrc_crc12_40b_eng.sv
// Scoreboard bench for ippcrc_crc12_40b_eng: stimulus pushes expected results,
// a negedge monitor pops and compares on every result handshake.

module tb_ippcrc_crc12_40b_eng;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_mode, i_vld, i_rdy, i_sop, i_eop;
  logic [39:0] i_dat;
  logic [11:0] i_crc_exp;
  logic        o_vld, o_rdy, o_chk_ok, o_err;
  logic [11:0] o_crc;
  logic [15:0] o_wcnt;
`ifdef IPPCRC_CRC12_ENG_STAT_EN
  logic [31:0] o_frm_cnt, o_bad_cnt;
`endif

  always #5 clk = ~clk;

  ippcrc_crc12_40b_eng dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_vld(i_vld), .i_rdy(i_rdy),
    .i_sop(i_sop), .i_eop(i_eop), .i_dat(i_dat), .i_crc_exp(i_crc_exp),
    .o_vld(o_vld), .o_rdy(o_rdy), .o_crc(o_crc), .o_chk_ok(o_chk_ok),
    .o_wcnt(o_wcnt), .o_err(o_err)
`ifdef IPPCRC_CRC12_ENG_STAT_EN
    , .o_frm_cnt(o_frm_cnt), .o_bad_cnt(o_bad_cnt)
`endif
  );

  typedef struct {
    logic [11:0] crc;
    logic        ok;
    logic [15:0] wcnt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   err_seen = 0;

  localparam logic [39:0] D0 = 40'hA5_1234_5678;
  localparam logic [39:0] D1 = 40'h00_FFFF_0001;
  localparam logic [39:0] D2 = 40'h80_0000_0000;
  localparam logic [39:0] D3 = 40'h12_3456_789A;
  localparam logic [39:0] D4 = 40'hFF_0000_00FF;

  // Reference: long division of (ci*x^40 + D*x^12) by x^12+x^11+x^3+x^2+x+1,
  // where di[0] is the most significant data coefficient.
  function automatic logic [11:0] crc_model(input logic [11:0] ci, input logic [39:0] di);
    logic [51:0] m;
    m = {ci, 40'd0};
    for (int j = 0; j < 40; j++) m[51-j] = m[51-j] ^ di[j];
    for (int k = 51; k >= 12; k--) begin
      if (m[k]) m[k -: 13] = m[k -: 13] ^ 13'h180F;
    end
    return m[11:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [11:0] crc, input logic ok, input logic [15:0] wcnt);
    exp_t e;
    e.crc = crc; e.ok = ok; e.wcnt = wcnt;
    sb_q.push_back(e);
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic sop, input logic eop, input logic [39:0] dat,
                      input logic mode, input logic [11:0] exp_crc, output int waits);
    logic acc;
    i_vld = 1'b1; i_sop = sop; i_eop = eop; i_dat = dat;
    i_mode = mode; i_crc_exp = exp_crc;
    waits = 0;
    acc = 1'b0;
    while (!acc) begin
      @(negedge clk);
      acc = i_rdy;
      @(posedge clk);
      if (!acc) waits++;
      if (waits > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: got no i_rdy expected i_rdy within 50 cycles");
        break;
      end
    end
    #1;
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every result handshake and count error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_err) err_seen++;
      if (o_vld && o_rdy) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got crc %0h expected no result", o_crc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("res_crc", {20'd0, o_crc}, {20'd0, e.crc});
          check("res_chk_ok", {31'd0, o_chk_ok}, {31'd0, e.ok});
          check("res_wcnt", {16'd0, o_wcnt}, {16'd0, e.wcnt});
        end
      end
    end
  end

  initial begin
    int w;
    int e0;
    logic [11:0] c;

    rst = 1'b1; i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_dat = 40'd0;
    i_mode = 1'b0; i_crc_exp = 12'h000; o_rdy = 1'b1;
    @(negedge clk);
    check("rdy_in_rst", {31'd0, i_rdy}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_i_rdy", {31'd0, i_rdy}, 32'd1);
    check("rst_o_vld", {31'd0, o_vld}, 32'd0);
    check("rst_o_crc", {20'd0, o_crc}, 32'd0);
    check("rst_o_chk_ok", {31'd0, o_chk_ok}, 32'd0);
    check("rst_o_wcnt", {16'd0, o_wcnt}, 32'd0);
    check("rst_o_err", {31'd0, o_err}, 32'd0);
    idle_cycles(1);

    // 1: zero word, generate mode, one-cycle latency
    push_exp(12'h000, 1'b1, 16'd1);
    send(1'b1, 1'b1, 40'd0, 1'b0, 12'h000, w);
    @(negedge clk);
    check("latency_o_vld", {31'd0, o_vld}, 32'd1);
    idle_cycles(1);

    // 2: single low bit and single top bit (hand-divided)
    push_exp(12'h0D0, 1'b1, 16'd1);
    send(1'b1, 1'b1, 40'h00_0000_0001, 1'b0, 12'h000, w);
    push_exp(12'h80F, 1'b1, 16'd1);
    send(1'b1, 1'b1, D2, 1'b0, 12'h000, w);

    // 3: check mode pass then fail
    push_exp(12'h0D0, 1'b1, 16'd1);
    send(1'b1, 1'b1, 40'h00_0000_0001, 1'b1, 12'h0D0, w);
    push_exp(12'h0D0, 1'b0, 16'd1);
    send(1'b1, 1'b1, 40'h00_0000_0001, 1'b1, 12'h0D1, w);
    idle_cycles(2);

    // 4: 5-word frame under backpressure, then same-cycle sop acceptance
    o_rdy = 1'b0;
    c = crc_model(12'h000, D0);
    c = crc_model(c, D1);
    c = crc_model(c, D2);
    c = crc_model(c, D3);
    c = crc_model(c, D4);
    push_exp(c, 1'b1, 16'd5);
    send(1'b1, 1'b0, D0, 1'b0, 12'h000, w);
    send(1'b0, 1'b0, D1, 1'b1, 12'hFFF, w);
    send(1'b0, 1'b0, D2, 1'b1, 12'hFFF, w);
    send(1'b0, 1'b0, D3, 1'b1, 12'hFFF, w);
    send(1'b0, 1'b1, D4, 1'b1, 12'hFFF, w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_i_rdy", {31'd0, i_rdy}, 32'd0);
      check("bp_o_vld", {31'd0, o_vld}, 32'd1);
      check("bp_o_crc", {20'd0, o_crc}, {20'd0, c});
      check("bp_o_wcnt", {16'd0, o_wcnt}, 32'd5);
      check("bp_o_chk_ok", {31'd0, o_chk_ok}, 32'd1);
    end
    @(posedge clk);
    #1 o_rdy = 1'b1;
    push_exp(12'h0D0, 1'b1, 16'd1);
    send(1'b1, 1'b1, 40'h00_0000_0001, 1'b0, 12'h000, w);
    check("sop_same_cycle_waits", w, 32'd0);
    idle_cycles(2);

    // 5: sop abort inside an open frame
    e0 = err_seen;
    c = crc_model(12'h000, D3);
    c = crc_model(c, D4);
    c = crc_model(c, D2);
    push_exp(c, 1'b1, 16'd3);
    send(1'b1, 1'b0, D0, 1'b0, 12'h000, w);
    send(1'b0, 1'b0, D1, 1'b0, 12'h000, w);
    send(1'b0, 1'b0, D2, 1'b0, 12'h000, w);
    send(1'b1, 1'b0, D3, 1'b0, 12'h000, w);
    send(1'b0, 1'b0, D4, 1'b0, 12'h000, w);
    send(1'b0, 1'b1, D2, 1'b0, 12'h000, w);
    idle_cycles(3);
    check("abort_err_count", err_seen - e0, 32'd1);

    // 6a: stray word while idle
    e0 = err_seen;
    send(1'b0, 1'b1, 40'h00_0000_1234, 1'b0, 12'h000, w);
    @(negedge clk);
    check("stray_no_vld", {31'd0, o_vld}, 32'd0);
    idle_cycles(3);
    check("stray_err_count", err_seen - e0, 32'd1);
    push_exp(12'h80F, 1'b1, 16'd1);
    send(1'b1, 1'b1, D2, 1'b0, 12'h000, w);
    idle_cycles(2);

    // 6b: reset in the middle of a frame
    e0 = err_seen;
    send(1'b1, 1'b0, D0, 1'b0, 12'h000, w);
    send(1'b0, 1'b0, D1, 1'b0, 12'h000, w);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_i_rdy", {31'd0, i_rdy}, 32'd0);
    check("midrst_o_vld", {31'd0, o_vld}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle_cycles(2);
    check("postrst_o_vld", {31'd0, o_vld}, 32'd0);
    push_exp(12'h0D0, 1'b1, 16'd1);
    send(1'b1, 1'b1, 40'h00_0000_0001, 1'b0, 12'h000, w);
    idle_cycles(3);
    check("rst_no_err", err_seen - e0, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
